// File: rtl/sparc_fetch_pkg.sv
// Shared encodings and types for the SPARC fetch front end.
package sparc_fetch_pkg;

    localparam logic [1:0] REDIR_NONE = 2'b00;
    localparam logic [1:0] REDIR_TA   = 2'b01;
    localparam logic [1:0] REDIR_ALU  = 2'b10;
    localparam logic [1:0] REDIR_RSVD = 2'b11;

    localparam int PC_INC = 4;

    // Entry layout for the standard 32-bit configuration; the FIFO itself stores {pc, instr} flat.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/sparc_fetch_fifo.sv
// Circular prefetch buffer with push/pop, full flush and flush-keeping-head.
module sparc_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    input  logic                   flush_all,
    input  logic                   flush_keep_head,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rp, wp, rp_nxt;
    logic          flush, keep;

    assign flush  = flush_all || flush_keep_head;
    assign rp_nxt = pop ? rp + 1'b1 : rp;
    // A same-cycle pop consumes the kept head, so the queue ends empty.
    assign keep   = flush_keep_head && !flush_all && !pop && (count != '0);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            rp <= rp_nxt;
            if (flush) begin
                wp    <= rp_nxt + PW'(keep);
                count <= CW'(keep);
            end else begin
                if (push) wp <= wp + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wp] <= push_data;
    end

    assign head = mem[rp];

endmodule

// File: rtl/sparc_fetch_queue.sv
// SPARC fetch front end: PC/nPC sequencing, ROM drive, prefetch queue and delayed-CTI redirects.
// Optional macro FETCH_ALIGN_CHK_EN adds a sticky misaligned-target fault port.
module sparc_fetch_queue
    import sparc_fetch_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              INSTR_W  = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    output logic [ADDR_W-1:0]      imem_addr,
    input  logic [INSTR_W-1:0]     imem_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_pc,
    output logic [INSTR_W-1:0]     out_instr,
    input  logic                   redir_valid,
    input  logic [1:0]             redir_sel,
    input  logic [ADDR_W-1:0]      redir_ta,
    input  logic [ADDR_W-1:0]      redir_alu,
    input  logic                   redir_annul,
    output logic [$clog2(DEPTH):0] count
`ifdef FETCH_ALIGN_CHK_EN
    ,
    output logic                   fault
`endif
);
    localparam int W = ADDR_W + INSTR_W;
    localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

    if (INSTR_W != 32) begin : g_bad_instr_w
        $error("sparc_fetch_queue: INSTR_W must be 32");
    end
    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sparc_fetch_queue: DEPTH must be a power of two in 2..16");
    end

    logic [ADDR_W-1:0] pc, npc, target_raw, target;
    logic [W-1:0]      head;
    logic              redir_go, bad_tgt, halt, pop, fetch, flush_all, flush_keep;

    always_comb begin
        redir_go   = 1'b0;
        target_raw = redir_ta;
        case (redir_sel)
            REDIR_TA:   begin redir_go = redir_valid; target_raw = redir_ta;  end
            REDIR_ALU:  begin redir_go = redir_valid; target_raw = redir_alu; end
            REDIR_NONE,
            REDIR_RSVD: redir_go = 1'b0;
            default:    redir_go = 1'b0;
        endcase
    end

`ifdef FETCH_ALIGN_CHK_EN
    assign target  = target_raw;
    assign bad_tgt = redir_go && (target_raw[1:0] != 2'b00);
    assign halt    = fault;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr)         fault <= 1'b0;
        else if (bad_tgt) fault <= 1'b1;
    end
`else
    assign target  = target_raw & ~ADDR_W'(3);
    assign bad_tgt = 1'b0;
    assign halt    = 1'b0;
`endif

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign fetch      = !redir_go && !halt && ((count != ($clog2(DEPTH)+1)'(DEPTH)) || pop);
    assign flush_all  = redir_go && (redir_annul || bad_tgt);
    assign flush_keep = redir_go && !redir_annul && !bad_tgt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + INC;
        end else if (redir_go && !bad_tgt) begin
            // Delay slot not fetched yet: fetch it from nPC, then continue at the target.
            if (!redir_annul && !out_valid) begin
                pc  <= npc;
                npc <= target;
            end else begin
                pc  <= target;
                npc <= target + INC;
            end
        end else if (fetch) begin
            pc  <= npc;
            npc <= npc + INC;
        end
    end

    sparc_fetch_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk             (clk),
        .clr             (clr),
        .push            (fetch),
        .push_data       ({pc, imem_data}),
        .pop             (pop),
        .flush_all       (flush_all),
        .flush_keep_head (flush_keep),
        .head            (head),
        .count           (count)
    );

    assign imem_addr = pc;
    assign out_pc    = out_valid ? head[W-1 -: ADDR_W]   : '0;
    assign out_instr = out_valid ? head[INSTR_W-1:0]     : '0;

endmodule

// File: tb/tb_sparc_fetch_queue.sv
// Directed bench for sparc_fetch_queue (DEPTH=4, RESET_PC=0) with hand-computed expectations.
module tb_sparc_fetch_queue;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] imem_addr, imem_data, out_pc, out_instr, redir_ta, redir_alu;
    logic        out_valid, out_ready, redir_valid, redir_annul;
    logic [1:0]  redir_sel;
    logic [2:0]  count;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fault;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // ROM: nops in the first three words, address-tagged words elsewhere.
    assign imem_data = (imem_addr < 32'd12) ? 32'h0100_0000 : {8'hA0, imem_addr[23:0]};

    sparc_fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0), .INSTR_W(32)) dut (
        .clk         (clk),
        .clr         (clr),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .redir_valid (redir_valid),
        .redir_sel   (redir_sel),
        .redir_ta    (redir_ta),
        .redir_alu   (redir_alu),
        .redir_annul (redir_annul),
        .count       (count)
`ifdef FETCH_ALIGN_CHK_EN
        ,
        .fault       (fault)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [1:0] sel, input logic [31:0] tgt, input logic annul);
        redir_valid = 1'b1;
        redir_sel   = sel;
        redir_ta    = tgt;
        redir_alu   = tgt;
        redir_annul = annul;
    endtask

    task automatic no_redir();
        redir_valid = 1'b0;
        redir_sel   = 2'b00;
        redir_annul = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        clr = 1'b0;
        #2;
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; out_ready = 1'b0; redir_ta = '0; redir_alu = '0;
        no_redir();
        #12;
        chk("rst_count", 64'(count), 0);
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_pc", 64'(out_pc), 0);
        chk("rst_instr", 64'(out_instr), 0);
        chk("rst_addr", 64'(imem_addr), 0);

        // Fill latency and streaming
        tick(); clr = 1'b1; out_ready = 1'b1;
        chk("pre_fill_valid", 64'(out_valid), 0);
        tick();
        chk("fill_valid", 64'(out_valid), 1);
        chk("fill_pc0", 64'(out_pc), 0);
        chk("fill_instr0", 64'(out_instr), 64'h0100_0000);
        tick(); chk("stream_pc4", 64'(out_pc), 4);
        tick(); chk("stream_pc8", 64'(out_pc), 8);
        chk("stream_count", 64'(count), 1);
        chk("stream_addr", 64'(imem_addr), 12);

        // Stall: queue saturates, PC holds
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        chk("full_count", 64'(count), 4);
        chk("full_addr", 64'(imem_addr), 16);
        chk("full_pc", 64'(out_pc), 0);

        // Pop and push while full
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("popush_count", 64'(count), 4);
        chk("popush_addr", 64'(imem_addr), 20);
        chk("popush_pc", 64'(out_pc), 4);

        // Pop the CTI at 4, head becomes delay slot 8; redirect keeping it
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("ds_head", 64'(out_pc), 8);
        redir(2'b01, 32'h40, 1'b0); tick(); no_redir();
        chk("keep_pc", 64'(out_pc), 8);
        chk("keep_count", 64'(count), 1);
        chk("keep_addr", 64'(imem_addr), 32'h40);
        out_ready = 1'b1;
        tick(); chk("keep_tgt", 64'(out_pc), 32'h40);
        tick(); chk("keep_tgt4", 64'(out_pc), 32'h44);

        // Annulled redirect with a concurrent pop
        redir(2'b01, 32'h80, 1'b1); tick(); no_redir();
        chk("annul_valid", 64'(out_valid), 0);
        chk("annul_count", 64'(count), 0);
        chk("annul_addr", 64'(imem_addr), 32'h80);
        tick();
        chk("annul_pc", 64'(out_pc), 32'h80);
        chk("annul_instr", 64'(out_instr), 64'hA000_0080);

        // Keep-head redirect with pop in the same cycle ends empty
        redir(2'b10, 32'h100, 1'b0); tick(); no_redir();
        chk("kpop_count", 64'(count), 0);
        chk("kpop_addr", 64'(imem_addr), 32'h100);
        tick(); chk("kpop_pc", 64'(out_pc), 32'h100);

        // Reserved selects are ignored
        redir(2'b11, 32'h200, 1'b1); tick();
        chk("sel11_pc", 64'(out_pc), 32'h104);
        chk("sel11_addr", 64'(imem_addr), 32'h108);
        redir(2'b00, 32'h200, 1'b1); tick(); no_redir();
        chk("sel00_pc", 64'(out_pc), 32'h108);

        // Wrap at top of address space
        redir(2'b01, 32'hFFFF_FFFC, 1'b1); tick(); no_redir();
        tick();
        chk("wrap_pc", 64'(out_pc), 32'hFFFF_FFFC);
        chk("wrap_addr", 64'(imem_addr), 0);

        // Misaligned target
        redir(2'b10, 32'h42, 1'b1); tick(); no_redir();
        chk("mis_count", 64'(count), 0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis_fault", 64'(fault), 1);
        chk("mis_addr", 64'(imem_addr), 0);
        tick(); tick();
        chk("mis_halt_count", 64'(count), 0);
        chk("mis_halt_addr", 64'(imem_addr), 0);
`else
        chk("mis_addr", 64'(imem_addr), 32'h40);
        tick();
        chk("mis_pc", 64'(out_pc), 32'h40);
`endif

        // Asynchronous reset mid-operation
        tick(); clr = 1'b0; #1;
        chk("arst_count", 64'(count), 0);
        chk("arst_valid", 64'(out_valid), 0);
        chk("arst_addr", 64'(imem_addr), 0);
`ifdef FETCH_ALIGN_CHK_EN
        chk("arst_fault", 64'(fault), 0);
`endif

        // Redirect before the delay slot is fetched
        tick(); clr = 1'b1; out_ready = 1'b1;
        redir(2'b01, 32'h40, 1'b0); tick(); no_redir();
        chk("nods_count", 64'(count), 0);
        chk("nods_addr", 64'(imem_addr), 4);
        tick();
        chk("nods_pc_ds", 64'(out_pc), 4);
        chk("nods_addr2", 64'(imem_addr), 32'h40);
        tick();
        chk("nods_pc_tgt", 64'(out_pc), 32'h40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
